// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input valid/ready stream mux with one registered output stage.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic             load;
  logic             any_req;
  logic             xfer;
  logic [SEL_W-1:0] gnt_idx;
  logic [N-1:0]     gnt;
  logic [WIDTH-1:0] gnt_data;

  assign load    = ~out_valid | out_ready;
  assign any_req = |in_valid;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] last_gnt;
  logic [SEL_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    // Walk from farthest to nearest so the first requester after last_gnt wins.
    for (int k = N; k >= 1; k--) begin
      cand = SEL_W'((int'(last_gnt) + k) % N);
      if (in_valid[cand]) gnt_idx = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= SEL_W'(N - 1);
    end else if (xfer) begin
      last_gnt <= gnt_idx;
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) gnt_idx = SEL_W'(k);
    end
  end
`endif

  always_comb begin
    gnt          = '0;
    gnt[gnt_idx] = any_req;
  end

  assign in_ready = {N{load & ~reset}} & gnt;
  assign xfer     = |in_ready;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: per-cycle model comparison plus directed literal checks.
// Expectations follow STREAM_MUX_RR_EN (round-robin when defined, fixed priority otherwise).
module tb_stream_mux_rr;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_sel;

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  // Model: winner is the requester closest after the previous winner (RR) or lowest index.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int best  = -1;
    int bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef STREAM_MUX_RR_EN
        int d = (i - last - 1 + 2 * N) % N;
`else
        int d = i;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_last;
  bit               started = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    if (started) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_sel", 64'(out_sel), 64'(m_sel));
      end
    end
    if (reset) begin
      chk("in_ready_rst", 64'(in_ready), 64'(0));
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_last  = N - 1;
      started = 1;
    end else if (started) begin
      g = pick(in_valid, m_last);
      if ((!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (exp_rdy != 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_sel   = g;
        m_last  = g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq_rr [6];
    int seq_alt[4];
`ifdef STREAM_MUX_RR_EN
    seq_rr  = '{0, 1, 2, 3, 0, 1};
    seq_alt = '{1, 3, 1, 3};
`else
    seq_rr  = '{0, 0, 0, 0, 0, 0};
    seq_alt = '{1, 1, 1, 1};
`endif
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, WIDTH'(32'hA0 + i));

    // Reset held two cycles with every channel requesting.
    step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_sel", 64'(out_sel), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(0));
    step();
    chk("rst_ready2", 64'(in_ready), 64'(0));
    reset = 1'b0;

    // Continuous requests, no gaps.
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_valid", 64'(out_valid), 64'(1));
      chk("rr_sel", 64'(out_sel), 64'(seq_rr[k]));
      chk("rr_data", 64'(out_data), 64'(32'hA0 + seq_rr[k]));
    end

    // Drain, then backpressure with channel 2 holding.
    in_valid = 4'b0000;
    step();
    chk("drain_valid", 64'(out_valid), 64'(0));
    in_valid = 4'b0100;
    set_data(2, 32'h1234);
    out_ready = 1'b0;
    step();
    set_data(2, 32'h5678);
    for (int k = 0; k < 3; k++) begin
      chk("bp_data", 64'(out_data), 64'(32'h1234));
      chk("bp_sel", 64'(out_sel), 64'(2));
      chk("bp_ready", 64'(in_ready), 64'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", 64'(out_data), 64'(32'h5678));
    in_valid = 4'b0000;
    step();
    chk("bp_drain", 64'(out_valid), 64'(0));

    // Sparse: channel 3 alone, then channel 1 alone.
    in_valid = 4'b1000;
    set_data(3, 32'h33);
    step();
    chk("sp_sel3", 64'(out_sel), 64'(3));
    chk("sp_data3", 64'(out_data), 64'(32'h33));
    in_valid = 4'b0010;
    set_data(1, 32'h11);
    step();
    chk("sp_sel1", 64'(out_sel), 64'(1));
    in_valid = 4'b0000;
    step();
    chk("sp_idle", 64'(out_valid), 64'(0));

    // Mid-stream reset discards a held beat and restarts at channel 0.
    in_valid = 4'b0001;
    set_data(0, 32'hDEAD);
    out_ready = 1'b0;
    step();
    chk("mr_held", 64'(out_data), 64'(32'hDEAD));
    reset    = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, WIDTH'(32'hA0 + i));
    step();
    chk("mr_valid", 64'(out_valid), 64'(0));
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mr_sel", 64'(out_sel), 64'(0));

    // Channels 1 and 3 requesting persistently.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_sel", 64'(out_sel), 64'(seq_alt[k]));
    end
    in_valid = 4'b0000;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
